// File: rtl/period_detector_pkg.sv
// Shared widths, thresholds and state encoding for the period/duty detector.
// Samples are unsigned offset-binary; crossings use a hysteresis window about the midpoint.
package period_detector_pkg;

  localparam int AUDIO_BIT_WIDTH = 16;
  localparam int PERIOD_WIDTH    = 12;
  localparam int PERCENT_WIDTH   = 8;
  localparam int LOCK_TOL        = 2;

  typedef logic [PERIOD_WIDTH-1:0]    period_t;
  typedef logic [PERCENT_WIDTH-1:0]   percent_t;
  typedef logic [AUDIO_BIT_WIDTH-1:0] audio_t;

  localparam audio_t MIDPOINT   = audio_t'(1) << (AUDIO_BIT_WIDTH - 1);
  localparam audio_t HYSTERESIS = audio_t'(1) << (AUDIO_BIT_WIDTH - 4);
  localparam audio_t RISE_LEVEL = MIDPOINT + HYSTERESIS;
  localparam audio_t FALL_LEVEL = MIDPOINT - HYSTERESIS;

  // Sum value one below saturation: the next counted sample would saturate.
  localparam period_t SAT_SUM = period_t'((1 << PERIOD_WIDTH) - 2);

  typedef enum logic [1:0] {
    ARM,
    WAIT_RISE,
    HIGH,
    LOW
  } detector_state_t;

endpackage

// File: rtl/period_detector_duty_divider.sv
// Restoring divider: duty = floor(high * 2**PERCENT_WIDTH / period), one quotient bit per clock.
// Loads on i_start when idle, o_done pulses PERCENT_WIDTH+1 clocks after start; i_start ignored while busy.
module period_detector_duty_divider
  import period_detector_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_abort,
  input  logic     i_start,
  input  period_t  i_high,
  input  period_t  i_period,
  output logic     o_busy,
  output logic     o_done,
  output period_t  o_period,
  output percent_t o_duty
);

  localparam int CNT_W = $clog2(PERCENT_WIDTH);

  period_t          r_rem;
  period_t          r_div;
  percent_t         r_quot;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic [PERIOD_WIDTH:0] w_shift;
  logic [PERIOD_WIDTH:0] w_diff;
  logic                  w_ge;

  // Remainder stays below the divisor, so the shifted value needs one extra bit only.
  assign w_shift = {r_rem, 1'b0};
  assign w_ge    = w_shift >= {1'b0, r_div};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (i_abort) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_rem  <= w_ge ? w_diff[PERIOD_WIDTH-1:0] : w_shift[PERIOD_WIDTH-1:0];
        r_quot <= {r_quot[PERCENT_WIDTH-2:0], w_ge};
        r_cnt  <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(PERCENT_WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (i_start) begin
        r_rem  <= i_high;
        r_div  <= i_period;
        r_ovf  <= i_high >= i_period;
        r_quot <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_period = r_div;
  assign o_duty   = r_ovf ? '1 : r_quot;

endmodule

// File: rtl/period_detector.sv
// Tracks hysteresis crossings and publishes period/duty PERCENT_WIDTH+2 clocks after each capture.
// No backpressure: captures arriving while the divider is busy are dropped and flagged by overrun.
module period_detector
  import period_detector_pkg::*;
(
  input  logic                       clock_50_000_000,
  input  logic                       reset_l,
  input  logic                       clear,
  input  logic                       sample_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0] sample,
  output logic [PERIOD_WIDTH-1:0]    period,
  output percent_t                   duty_cycle,
  output logic                       measure_valid,
  output logic                       locked,
  output logic                       timeout,
  output logic                       overrun
);

  detector_state_t r_state;
  detector_state_t w_next_state;

  period_t  r_high_cnt;
  period_t  r_low_cnt;
  period_t  r_high_cap;
  period_t  r_period_cap;
  logic     r_start;

  logic     w_rise;
  logic     w_fall;
  logic     w_sat;
  period_t  w_sum;
  logic     w_capture;
  logic     w_timeout;
  logic     w_accept;
  logic     w_overrun;
  logic     w_div_busy;
  logic     w_div_done;
  period_t  w_div_period;
  percent_t w_div_duty;
  period_t  w_delta;
  logic     w_within;

  assign w_rise = sample_valid && (sample >= RISE_LEVEL);
  assign w_fall = sample_valid && (sample <= FALL_LEVEL);
  assign w_sum  = r_high_cnt + r_low_cnt;
  assign w_sat  = sample_valid && (w_sum == SAT_SUM);

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) r_state <= ARM;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ARM;
    end else begin
      case (r_state)
        ARM:       if (w_fall) w_next_state = WAIT_RISE;
        WAIT_RISE: if (w_rise) w_next_state = HIGH;
        HIGH: begin
          if (w_sat)       w_next_state = ARM;
          else if (w_fall) w_next_state = LOW;
        end
        LOW: begin
          if (w_rise)     w_next_state = HIGH;
          else if (w_sat) w_next_state = ARM;
        end
        default: w_next_state = ARM;
      endcase
    end
  end

  // A capturing rise in LOW wins over saturation on the same sample.
  always_comb begin
    w_capture = (r_state == LOW) && w_rise;
    w_timeout = ((r_state == HIGH) && w_sat) || ((r_state == LOW) && !w_rise && w_sat);
    w_accept  = w_capture && !(r_start || w_div_busy);
    w_overrun = w_capture && (r_start || w_div_busy);
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_high_cap   <= '0;
      r_period_cap <= '0;
      r_start      <= 1'b0;
    end else if (clear) begin
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_high_cap   <= '0;
      r_period_cap <= '0;
      r_start      <= 1'b0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_high_cap   <= r_high_cnt;
        r_period_cap <= w_sum;
      end
      if (w_timeout) begin
        r_high_cnt <= '0;
        r_low_cnt  <= '0;
      end else if (sample_valid) begin
        case (r_state)
          WAIT_RISE: if (w_rise) begin
            r_high_cnt <= period_t'(1);
            r_low_cnt  <= '0;
          end
          HIGH: begin
            if (w_fall) r_low_cnt  <= period_t'(1);
            else        r_high_cnt <= r_high_cnt + period_t'(1);
          end
          LOW: begin
            if (w_rise) begin
              r_high_cnt <= period_t'(1);
              r_low_cnt  <= '0;
            end else begin
              r_low_cnt <= r_low_cnt + period_t'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  period_detector_duty_divider u_divider (
    .i_clk    (clock_50_000_000),
    .i_rst_n  (reset_l),
    .i_abort  (clear),
    .i_start  (r_start),
    .i_high   (r_high_cap),
    .i_period (r_period_cap),
    .o_busy   (w_div_busy),
    .o_done   (w_div_done),
    .o_period (w_div_period),
    .o_duty   (w_div_duty)
  );

  assign w_delta  = (w_div_period > period) ? (w_div_period - period) : (period - w_div_period);
  assign w_within = w_delta <= period_t'(LOCK_TOL);

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      period        <= '0;
      duty_cycle    <= '0;
      measure_valid <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
      overrun       <= 1'b0;
    end else if (clear) begin
      period        <= '0;
      duty_cycle    <= '0;
      measure_valid <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      measure_valid <= w_div_done;
      timeout       <= w_timeout;
      overrun       <= w_overrun;
      if (w_div_done) begin
        period     <= w_div_period;
        duty_cycle <= w_div_duty;
        locked     <= w_within;
      end
      if (w_timeout) locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_period_detector.sv
// Drives square/noisy/random waves into period_detector and checks every cycle against
// an index-based reference model, plus table-driven and hand-written corner sequences.
module tb_period_detector;

  localparam int MID     = 1 << 15;
  localparam int HYS     = 1 << 12;
  localparam int RISE    = MID + HYS;
  localparam int FALL    = MID - HYS;
  localparam int PCT_W   = 8;
  localparam int SAT     = (1 << 12) - 1;
  localparam int DIV_LAT = PCT_W + 2;
  localparam int TOL     = 2;

  localparam int M_ARM = 0, M_WAIT = 1, M_HIGH = 2, M_LOW = 3;

  logic        clk;
  logic        reset_l;
  logic        clear;
  logic        sample_valid;
  logic [15:0] sample;
  logic [11:0] period;
  logic [7:0]  duty_cycle;
  logic        measure_valid;
  logic        locked;
  logic        timeout;
  logic        overrun;

  period_detector dut (
    .clock_50_000_000 (clk),
    .reset_l          (reset_l),
    .clear            (clear),
    .sample_valid     (sample_valid),
    .sample           (sample),
    .period           (period),
    .duty_cycle       (duty_cycle),
    .measure_valid    (measure_valid),
    .locked           (locked),
    .timeout          (timeout),
    .overrun          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ov_seen, to_seen, mv_seen;
  int gap_pct = 0;
  bit rnd_levels = 0;

  // Reference model: crossings tracked as sample indices, results as a scheduled publish.
  int m_mode, m_n, m_rise_n, m_fall_n, m_cyc;
  int m_pend, m_due, m_pp, m_pd, m_last_acc;
  int e_period, e_duty, e_locked, e_mv, e_to, e_ov;

  task automatic model_zero();
    m_mode = M_ARM; m_pend = 0; m_last_acc = -1000;
    e_period = 0; e_duty = 0; e_locked = 0; e_mv = 0; e_to = 0; e_ov = 0;
  endtask

  task automatic model_timeout();
    e_to = 1; e_locked = 0; m_mode = M_ARM;
  endtask

  task automatic model_step(input logic rl, input logic c, input logic v, input logic [15:0] s);
    int hi, per, d;
    bit r, f;
    m_cyc++;
    e_mv = 0; e_to = 0; e_ov = 0;
    if (!rl || c) begin
      model_zero();
      return;
    end
    if (m_pend != 0 && m_cyc == m_due) begin
      d = m_pp - e_period;
      if (d < 0) d = -d;
      e_locked = (d <= TOL) ? 1 : 0;
      e_period = m_pp; e_duty = m_pd; e_mv = 1; m_pend = 0;
    end
    if (v) begin
      r = int'(s) >= RISE;
      f = int'(s) <= FALL;
      m_n++;
      case (m_mode)
        M_ARM:  if (f) m_mode = M_WAIT;
        M_WAIT: if (r) begin m_mode = M_HIGH; m_rise_n = m_n; end
        M_HIGH: begin
          if (m_n - m_rise_n + 1 == SAT) model_timeout();
          else if (f) begin m_mode = M_LOW; m_fall_n = m_n; end
        end
        default: begin
          if (r) begin
            hi  = m_fall_n - m_rise_n;
            per = m_n - m_rise_n;
            if (m_cyc - m_last_acc >= DIV_LAT) begin
              m_pend = 1; m_due = m_cyc + DIV_LAT; m_pp = per;
              m_pd = (hi * (1 << PCT_W)) / per;
              if (m_pd > (1 << PCT_W) - 1) m_pd = (1 << PCT_W) - 1;
              m_last_acc = m_cyc;
            end else begin
              e_ov = 1;
            end
            m_rise_n = m_n; m_mode = M_HIGH;
          end else if (m_n - m_rise_n + 1 == SAT) begin
            model_timeout();
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("period", int'(period), e_period);
    chk("duty_cycle", int'(duty_cycle), e_duty);
    chk("measure_valid", int'(measure_valid), e_mv);
    chk("locked", int'(locked), e_locked);
    chk("timeout", int'(timeout), e_to);
    chk("overrun", int'(overrun), e_ov);
    ov_seen += int'(overrun);
    to_seen += int'(timeout);
    mv_seen += int'(measure_valid);
  endtask

  task automatic tick(input logic c, input logic v, input logic [15:0] s);
    clear = c; sample_valid = v; sample = s;
    model_step(reset_l, c, v, s);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic seg(input int len, input bit hi, input int noise);
    int i;
    logic [15:0] s;
    i = 0;
    while (i < len) begin
      if (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
        tick(1'b0, 1'b0, 16'($urandom));
      end else begin
        if (i < noise)   s = 16'(MID - HYS + 1 + $urandom_range(0, 2 * HYS - 2));
        else if (rnd_levels) s = hi ? 16'($urandom_range(RISE, 65535)) : 16'($urandom_range(0, FALL));
        else             s = hi ? 16'hFFFF : 16'h0000;
        tick(1'b0, 1'b1, s);
        i++;
      end
    end
  endtask

  typedef struct {
    int hi; int lo; int reps; int noise;
    int exp_period; int exp_duty; int exp_locked; int exp_ov;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat;
    tbl[0] = '{25, 75, 6, 0, 100, 64, 1, 0};
    tbl[1] = '{100, 100, 6, 0, 200, 128, 1, 0};
    tbl[2] = '{100, 100, 6, 10, 200, 128, 1, 0};
    tbl[3] = '{1, 1, 12, 0, 2, 128, 1, 1};
    tbl[4] = '{10, 30, 6, 0, 40, 64, 1, 0};
    tbl[5] = '{3, 7, 6, 0, 10, 76, 1, 0};
    tbl[6] = '{1, 254, 6, 0, 255, 1, 1, 0};
    tbl[7] = '{254, 1, 6, 0, 255, 254, 1, 0};

    reset_l = 1'b0; clear = 1'b0; sample_valid = 1'b0; sample = '0;
    m_cyc = 0; m_n = 0; m_rise_n = 0; m_fall_n = 0;
    model_zero();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_l = 1'b1;

    // Square-wave table.
    for (int t = 0; t < 8; t++) begin
      tick(1'b1, 1'b1, 16'h0000);
      ov_seen = 0;
      for (int r = 0; r < tbl[t].reps; r++) begin
        seg(tbl[t].hi, 1'b1, tbl[t].noise);
        seg(tbl[t].lo, 1'b0, tbl[t].noise);
      end
      seg(15, 1'b0, 0);
      chk("tbl_period", int'(period), tbl[t].exp_period);
      chk("tbl_duty", int'(duty_cycle), tbl[t].exp_duty);
      chk("tbl_locked", int'(locked), tbl[t].exp_locked);
      chk("tbl_overrun_seen", (ov_seen > 0) ? 1 : 0, tbl[t].exp_ov);
    end

    // Result latency from the capturing rise.
    tick(1'b1, 1'b1, 16'h0000);
    seg(25, 1'b1, 0); seg(75, 1'b0, 0); seg(25, 1'b1, 0); seg(75, 1'b0, 0);
    tick(1'b0, 1'b1, 16'hFFFF);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b1, 16'hFFFF);
      if (measure_valid && lat == 0) lat = k;
    end
    chk("mv_latency", lat, DIV_LAT);
    chk("latency_period", int'(period), 100);

    // Saturation while parked low.
    tick(1'b1, 1'b1, 16'h0000);
    for (int r = 0; r < 4; r++) begin seg(25, 1'b1, 0); seg(75, 1'b0, 0); end
    chk("pre_timeout_locked", int'(locked), 1);
    to_seen = 0;
    seg(4100, 1'b0, 0);
    chk("timeout_count", to_seen, 1);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_period_held", int'(period), 100);
    chk("timeout_duty_held", int'(duty_cycle), 64);

    // Clear mid-divide, then asynchronous reset mid-HIGH.
    tick(1'b1, 1'b1, 16'h0000);
    for (int r = 0; r < 3; r++) begin seg(25, 1'b1, 0); seg(75, 1'b0, 0); end
    seg(4, 1'b1, 0);
    tick(1'b1, 1'b1, 16'hFFFF);
    chk("clear_period", int'(period), 0);
    chk("clear_mv", int'(measure_valid), 0);
    mv_seen = 0;
    seg(15, 1'b1, 0);
    chk("clear_no_stale_mv", mv_seen, 0);
    seg(75, 1'b0, 0);
    for (int r = 0; r < 3; r++) begin seg(25, 1'b1, 0); seg(75, 1'b0, 0); end
    seg(10, 1'b1, 0);
    chk("pre_reset_period", int'(period), 100);
    reset_l = 1'b0;
    #1;
    model_zero();
    check_all();
    tick(1'b0, 1'b1, 16'hFFFF);
    reset_l = 1'b1;
    mv_seen = 0;
    seg(20, 1'b1, 0);
    chk("reset_no_stale_mv", mv_seen, 0);

    // Randomized waves with sample gaps, noise, boundary levels and sporadic clears.
    gap_pct = 20;
    rnd_levels = 1;
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 39) == 0) tick(1'b1, 1'($urandom), 16'($urandom));
      if ($urandom_range(0, 7) == 0) tick(1'b0, 1'b1, 16'(RISE));
      if ($urandom_range(0, 7) == 0) tick(1'b0, 1'b1, 16'(FALL + 1));
      seg($urandom_range(1, 40), 1'b1, $urandom_range(0, 3));
      seg($urandom_range(1, 60), 1'b0, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
